// File: rtl/data_ram_pkg.sv
// Shared encodings and defaults for the data-memory port between the core and data_ram.
package data_ram_pkg;

    localparam int REG_BUS = 32;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10,
        MEM_ILL  = 2'b11
    } mem_type_e;

    localparam logic [REG_BUS-1:0] DATA_BASE_ADDR = 32'h0000_0000;

endpackage

// File: rtl/data_ram_load_align.sv
// Load result formatting: picks the addressed byte/half out of a raw little-endian word
// and sign- or zero-extends it to the full register width.
module data_ram_load_align
    import data_ram_pkg::*;
(
    input  logic [REG_BUS-1:0] raw_i,
    input  logic [1:0]         type_i,
    input  logic               sign_i,
    input  logic [1:0]         bo_i,
    output logic [REG_BUS-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = raw_i[{bo_i, 3'b000} +: 8];
        half_v = bo_i[1] ? raw_i[31:16] : raw_i[15:0];
        data_o = '0;
        case (type_i)
            MEM_BYTE: data_o = {{24{sign_i & byte_v[7]}}, byte_v};
            MEM_HALF: data_o = {{16{sign_i & half_v[15]}}, half_v};
            MEM_WORD: data_o = raw_i;
            default:  data_o = '0;
        endcase
    end

endmodule

// File: rtl/data_ram.sv
// Single-port data memory for the core's load/store path: byte-lane stores, 1-cycle loads,
// and sticky misalignment / out-of-range error flags.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int                 DEPTH_WORDS = 4096,
    parameter logic [REG_BUS-1:0] BASE_ADDR   = DATA_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [REG_BUS-1:0] mem_addr,
    input  logic [REG_BUS-1:0] mem_wdata,
    input  logic [1:0]         mem_type,
    input  logic               mem_sign,
    input  logic               rmem,
    input  logic               wmem,
    output logic [REG_BUS-1:0] mem_rdata,
    output logic               err_misalign,
    output logic               err_range,
    input  logic               err_clr
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [REG_BUS-1:0] off;
    logic [AW-1:0]      idx;
    logic [1:0]         bo;
    logic               access;
    logic               in_range;
    logic               bad_align;
    logic               lgl;
    logic [3:0]         be;
    logic [REG_BUS-1:0] wlanes;

    logic [REG_BUS-1:0] mem_q [DEPTH_WORDS];

    logic [REG_BUS-1:0] rd_word_q;
    logic [1:0]         rd_type_q;
    logic               rd_sign_q;
    logic [1:0]         rd_bo_q;
    logic               rd_vld_q;
    logic               err_misalign_q;
    logic               err_range_q;
    logic [REG_BUS-1:0] aligned;

    assign off      = mem_addr - BASE_ADDR;
    assign idx      = off[AW+1:2];
    assign bo       = off[1:0];
    assign access   = rmem | wmem;
    // Addresses below BASE_ADDR wrap to huge offsets, so one unsigned compare covers both ends.
    assign in_range = (off >> (AW + 2)) == '0;
    assign lgl      = in_range & ~bad_align;

    always_comb begin
        bad_align = 1'b0;
        be        = 4'b0000;
        wlanes    = mem_wdata;
        case (mem_type)
            MEM_BYTE: begin
                be     = 4'b0001 << bo;
                wlanes = {4{mem_wdata[7:0]}};
            end
            MEM_HALF: begin
                bad_align = bo[0];
                be        = bo[1] ? 4'b1100 : 4'b0011;
                wlanes    = {2{mem_wdata[15:0]}};
            end
            MEM_WORD: begin
                bad_align = bo != 2'b00;
                be        = 4'b1111;
            end
            default: bad_align = 1'b1;
        endcase
    end

    // Storage is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wmem && lgl) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][b*8 +: 8] <= wlanes[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_word_q      <= '0;
            rd_type_q      <= 2'b00;
            rd_sign_q      <= 1'b0;
            rd_bo_q        <= 2'b00;
            rd_vld_q       <= 1'b0;
            err_misalign_q <= 1'b0;
            err_range_q    <= 1'b0;
        end else begin
            rd_vld_q <= rmem & lgl;
            if (rmem) begin
                rd_word_q <= mem_q[idx];
                rd_type_q <= mem_type;
                rd_sign_q <= mem_sign;
                rd_bo_q   <= bo;
            end
            err_misalign_q <= (access & bad_align) | (err_misalign_q & ~err_clr);
            err_range_q    <= (access & ~in_range) | (err_range_q & ~err_clr);
        end
    end

    data_ram_load_align u_load_align (
        .raw_i  (rd_word_q),
        .type_i (rd_type_q),
        .sign_i (rd_sign_q),
        .bo_i   (rd_bo_q),
        .data_o (aligned)
    );

    assign mem_rdata    = rd_vld_q ? aligned : '0;
    assign err_misalign = err_misalign_q;
    assign err_range    = err_range_q;

endmodule
